// File: rtl/doppler_spi_master.sv
// 16-bit mode-0 SPI master with CS setup/hold/idle framing and a 2-FF MISO synchroniser.
// Define DOPPLER_SPIM_LSB_FIRST_EN to shift LSB first (timing unchanged).
module doppler_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LAG      = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [15:0]   rxsh_q, rxsh_d;
  logic [15:0]   rx_data_q, rx_data_d;
  logic          miso_s1_q, miso_s2_q;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
  logic          phase_last;
  logic          tx_bit;
  logic [15:0]   tx_shifted;
  logic [15:0]   rx_shifted;

`ifdef DOPPLER_SPIM_LSB_FIRST_EN
  assign tx_shifted = {1'b0, tx_q[15:1]};
  assign rx_shifted = {miso_s2_q, rxsh_q[15:1]};
  assign tx_bit     = tx_d[0];
`else
  assign tx_shifted = {tx_q[14:0], 1'b0};
  assign rx_shifted = {rxsh_q[14:0], miso_s2_q};
  assign tx_bit     = tx_d[15];
`endif

  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      LEAD:               phase_last = (cnt_q == CW'(CS_SETUP - 1));
      SHIFT_LO, SHIFT_HI: phase_last = (cnt_q == CW'(CLK_DIV - 1));
      LAG:                phase_last = (cnt_q == CW'(CS_HOLD - 1));
      GAP:                phase_last = (cnt_q == CW'(CS_IDLE - 1));
      default:            phase_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rxsh_d    = rxsh_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = LEAD;
          tx_d    = tx_data;
          bit_d   = 4'd15;
          rxsh_d  = '0;
        end
      end
      LEAD: begin
        if (phase_last) begin
          state_d = SHIFT_LO;
          cnt_d   = '0;
        end
      end
      SHIFT_LO: begin
        // MISO is captured on the same edge that raises SCK.
        if (phase_last) begin
          state_d = SHIFT_HI;
          cnt_d   = '0;
          rxsh_d  = rx_shifted;
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          cnt_d = '0;
          if (bit_q == 4'd0) begin
            state_d = LAG;
          end else begin
            state_d = SHIFT_LO;
            bit_d   = bit_q - 4'd1;
            tx_d    = tx_shifted;
          end
        end
      end
      LAG: begin
        if (phase_last) begin
          state_d   = GAP;
          cnt_d     = '0;
          rx_data_d = rxsh_q;
          done_d    = 1'b1;
        end
      end
      GAP: begin
        if (phase_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they are glitch-free.
  always_comb begin
    sck_d  = (state_d == SHIFT_HI);
    cs_n_d = (state_d == IDLE) || (state_d == GAP);
    mosi_d = 1'b0;
    if ((state_d == LEAD) || (state_d == SHIFT_LO) ||
        (state_d == SHIFT_HI) || (state_d == LAG)) begin
      mosi_d = tx_bit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rxsh_q    <= '0;
      rx_data_q <= '0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rxsh_q    <= rxsh_d;
      rx_data_q <= rx_data_d;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_doppler_spi_master.sv
// Directed bench for doppler_spi_master: reset, loopback, slave model, handshake, mid-frame reset, bit order.
module tb_doppler_spi_master;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] tx_data;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  int errors = 0;
  int checks = 0;
  logic use_slave = 1'b0;

  typedef struct {
    int          done_k;
    int          busy_low_k;
    int          rises;
    int          first_rise_k;
    int          ndone;
    logic        mosi_k1;
    logic        busy_k1;
    logic        csn_k1;
    logic [15:0] rx_at_done;
    logic [15:0] mosi_bits;
  } frame_obs_t;

  doppler_spi_master dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Slave: synchronises CS/SCK, presents bit 15 at CS fall, shifts on SCK rise.
  logic [2:0]  slv_cs_s, slv_sck_s;
  logic [15:0] slv_tx, slv_rx, slv_latched;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slv_cs_s    <= 3'b111;
      slv_sck_s   <= 3'b000;
      slv_tx      <= 16'h0;
      slv_rx      <= 16'h0;
      slv_latched <= 16'h0;
    end else begin
      slv_cs_s  <= {slv_cs_s[1:0], spi_cs_n};
      slv_sck_s <= {slv_sck_s[1:0], spi_sck};
      if (slv_cs_s[2] && !slv_cs_s[1]) slv_tx <= 16'h53F0;
      else if (!slv_sck_s[2] && slv_sck_s[1] && !slv_cs_s[1]) begin
        slv_tx <= {slv_tx[14:0], 1'b0};
        slv_rx <= {slv_rx[14:0], spi_mosi};
      end
      if (!slv_cs_s[2] && slv_cs_s[1]) slv_latched <= slv_rx;
    end
  end

  assign spi_miso = use_slave ? slv_tx[15] : spi_mosi;

  // Starts a frame from IDLE and records what happens over the next 150 cycles (k = cycles after T0).
  task automatic run_frame(input logic [15:0] tx, output frame_obs_t o);
    logic prev_sck;
    o.done_k = -1; o.busy_low_k = -1; o.rises = 0; o.first_rise_k = -1; o.ndone = 0;
    o.rx_at_done = 16'hxxxx; o.mosi_bits = 16'h0;
    @(negedge clk);
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    o.mosi_k1 = spi_mosi;
    o.busy_k1 = busy;
    o.csn_k1  = spi_cs_n;
    prev_sck  = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      if (k > 1) @(negedge clk);
      if (spi_sck && !prev_sck) begin
        o.rises++;
        o.mosi_bits = {o.mosi_bits[14:0], spi_mosi};
        if (o.first_rise_k < 0) o.first_rise_k = k;
      end
      prev_sck = spi_sck;
      if (done) begin
        o.ndone++;
        if (o.done_k < 0) begin
          o.done_k     = k;
          o.rx_at_done = rx_data;
        end
      end
      if (!busy && o.busy_low_k < 0) o.busy_low_k = k;
    end
  endtask

  task automatic test_reset();
    int active;
    resetn = 1'b0; start = 1'b0; tx_data = 16'h0;
    #25;
    checks++;
    if ({spi_cs_n, spi_sck, spi_mosi, busy, done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pins: cs_n/sck/mosi/busy/done=%b expected 10000",
               {spi_cs_n, spi_sck, spi_mosi, busy, done});
    end
    checks++;
    if (rx_data !== 16'h0) begin
      errors++; $display("FAIL reset_rx: got %h expected 0000", rx_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    active = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({spi_cs_n, spi_sck, spi_mosi, busy, done} !== 5'b10000) active++;
    end
    checks++;
    if (active != 0) begin
      errors++; $display("FAIL reset_idle: %0d active cycles expected 0", active);
    end
  endtask

  task automatic test_loopback();
    frame_obs_t o;
    use_slave = 1'b0;
    run_frame(16'hA53C, o);
    checks++;
    if (o.rx_at_done !== 16'hA53C) begin
      errors++; $display("FAIL loop_rx: got %h expected a53c", o.rx_at_done);
    end
    checks++;
    if (o.done_k != 137) begin
      errors++; $display("FAIL loop_done_k: got %0d expected 137", o.done_k);
    end
    checks++;
    if (o.busy_low_k != 141) begin
      errors++; $display("FAIL loop_busy_low_k: got %0d expected 141", o.busy_low_k);
    end
    checks++;
    if (o.rises != 16) begin
      errors++; $display("FAIL loop_rises: got %0d expected 16", o.rises);
    end
    checks++;
    if (o.first_rise_k != 9) begin
      errors++; $display("FAIL loop_first_rise: got %0d expected 9", o.first_rise_k);
    end
    checks++;
    if ({o.busy_k1, o.csn_k1, o.mosi_k1} !== 3'b101) begin
      errors++; $display("FAIL loop_t1: busy/cs_n/mosi=%b expected 101", {o.busy_k1, o.csn_k1, o.mosi_k1});
    end
    checks++;
    if (o.ndone != 1) begin
      errors++; $display("FAIL loop_ndone: got %0d expected 1", o.ndone);
    end
  endtask

  task automatic test_slave();
    frame_obs_t o;
    use_slave = 1'b1;
    run_frame(16'h00FF, o);
    checks++;
    if (o.rx_at_done !== 16'h53F0) begin
      errors++; $display("FAIL slave_rx: got %h expected 53f0", o.rx_at_done);
    end
    checks++;
    if (slv_latched !== 16'h00FF) begin
      errors++; $display("FAIL slave_latched: got %h expected 00ff", slv_latched);
    end
    use_slave = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ndone_first, ndone_total, csn_high, done2_k;
    logic [15:0] rx1, rx2;
    logic busy141, busy142;
    ndone_first = 0; ndone_total = 0; csn_high = 0; done2_k = -1;
    rx1 = 16'hxxxx; rx2 = 16'hxxxx; busy141 = 1'bx; busy142 = 1'bx;
    use_slave = 1'b0;
    @(negedge clk);
    tx_data = 16'h0F0F;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 290; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        ndone_total++;
        if (k <= 141) begin ndone_first++; rx1 = rx_data; end
        else begin done2_k = k; rx2 = rx_data; end
      end
      if (k >= 130 && k <= 160 && spi_cs_n) csn_high++;
      if (k == 141) busy141 = busy;
      if (k == 142) busy142 = busy;
      if (k == 50) begin start = 1'b1; tx_data = 16'hFFFF; end
      if (k == 51) start = 1'b0;
      if (k == 100) begin start = 1'b1; tx_data = 16'h3C3C; end
      if (k == 142) start = 1'b0;
    end
    checks++;
    if (ndone_first != 1 || rx1 !== 16'h0F0F) begin
      errors++; $display("FAIL b2b_first: dones=%0d rx=%h expected 1 0f0f", ndone_first, rx1);
    end
    // CS stays high through the 4-cycle gap plus the IDLE accepting cycle.
    checks++;
    if (csn_high != 5) begin
      errors++; $display("FAIL b2b_csn_high: got %0d expected 5", csn_high);
    end
    checks++;
    if ({busy141, busy142} !== 2'b01) begin
      errors++; $display("FAIL b2b_busy: busy@141/142=%b expected 01", {busy141, busy142});
    end
    checks++;
    if (done2_k != 278 || rx2 !== 16'h3C3C || ndone_total != 2) begin
      errors++; $display("FAIL b2b_second: k=%0d rx=%h dones=%0d expected 278 3c3c 2", done2_k, rx2, ndone_total);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_obs_t o;
    int rises, ndone, csn_low;
    logic prev_sck;
    rises = 0; ndone = 0; csn_low = 0; prev_sck = 1'b0;
    use_slave = 1'b0;
    @(negedge clk);
    tx_data = 16'h5555;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200 && rises < 8; k++) begin
      if (k > 1) @(negedge clk);
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
    end
    checks++;
    if (rises != 8) begin
      errors++; $display("FAIL midrst_reach: rises=%0d expected 8", rises);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({spi_cs_n, spi_sck, busy, done} !== 4'b1000 || rx_data !== 16'h0) begin
      errors++; $display("FAIL midrst_pins: cs_n/sck/busy/done=%b rx=%h expected 1000 0000",
                         {spi_cs_n, spi_sck, busy, done}, rx_data);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!spi_cs_n) csn_low++;
    end
    checks++;
    if (ndone != 0 || csn_low != 0) begin
      errors++; $display("FAIL midrst_quiet: dones=%0d cs_low=%0d expected 0 0", ndone, csn_low);
    end
    run_frame(16'h1234, o);
    checks++;
    if (o.rx_at_done !== 16'h1234) begin
      errors++; $display("FAIL midrst_next_rx: got %h expected 1234", o.rx_at_done);
    end
  endtask

  task automatic test_bit_order();
    frame_obs_t o;
    logic [15:0] exp_bits;
`ifdef DOPPLER_SPIM_LSB_FIRST_EN
    exp_bits = 16'h8000;
`else
    exp_bits = 16'h0001;
`endif
    use_slave = 1'b0;
    run_frame(16'h0001, o);
    checks++;
    if (o.mosi_bits !== exp_bits) begin
      errors++; $display("FAIL order_mosi: sequence %h expected %h", o.mosi_bits, exp_bits);
    end
    checks++;
    if (o.rx_at_done !== 16'h0001) begin
      errors++; $display("FAIL order_rx: got %h expected 0001", o.rx_at_done);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
